// File: rtl/instr_align_expand.sv
// ---------------------------------------------------------------------------
// instr_align_expand
//
// Sits between instruction fetch and decode. Fetch delivers aligned 32-bit
// words; decode receives one 32-bit instruction per cycle with its PC.
//
// Build option (macro QUINTA_RVC_EN):
//   defined   : words are split into a circular halfword queue. Instructions
//               that straddle a word boundary are realigned, and C.NOP/C.ADDI
//               are expanded to their RV32 forms.
//   undefined : a single 32-bit word skid register. Each fetched word is one
//               instruction (pc += 4) and non-32-bit encodings are flagged
//               illegal. Redirect targets are treated as word aligned.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   fetch_valid/ready/data fetch word handshake; data[15:0] is the lower
//                          address halfword
//   flush, flush_pc        redirect: drop all buffered state, restart at pc
//   instr_valid/ready      decode handshake
//   instr_data             32-bit instruction (expanded if compressed)
//   instr_pc               address of the instruction's first halfword
//   instr_is_compressed    source was a 16-bit encoding
//   instr_illegal          unsupported encoding
//
// Parameters:
//   BUF_HW   halfword queue depth (minimum 4)
//   RESET_PC PC of the first instruction after reset
// ---------------------------------------------------------------------------
module instr_align_expand #(
  parameter int          BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_is_compressed,
  output logic        instr_illegal
);

  // Straddled 32-bit instructions plus a full incoming word need at least
  // four halfword slots to sustain one instruction per cycle.
  if (BUF_HW < 4) begin : g_buf_hw_too_small
    $error("instr_align_expand: BUF_HW must be at least 4");
  end

`ifdef QUINTA_RVC_EN

  localparam int AW = $clog2(BUF_HW);
  localparam int CW = $clog2(BUF_HW + 1);
  // Largest fill level that still leaves room for two halfwords.
  localparam logic [CW-1:0] MAX_FILL = CW'(BUF_HW - 2);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(BUF_HW);

  logic [15:0]   mem [BUF_HW];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   pc;
  logic          drop_hw;

  // Circular index advance that also works for non power-of-two depths.
  function automatic logic [AW-1:0] idx_add(input logic [AW-1:0] idx,
                                            input logic [1:0]    n);
    logic [AW:0] sum;
    sum = {1'b0, idx} + {{(AW - 1){1'b0}}, n};
    if (sum >= DEPTH) sum = sum - DEPTH;
    return sum[AW-1:0];
  endfunction

  logic [15:0] hw0;
  logic [15:0] hw1;
  logic        is_32;
  logic        out_valid;
  logic        in_fire;
  logic        out_fire;
  logic [1:0]  n_in;
  logic [1:0]  n_out;
  logic [31:0] sel_data;
  logic        sel_illegal;

  assign hw0   = mem[head];
  assign hw1   = mem[idx_add(head, 2'd1)];
  assign is_32 = (hw0[1:0] == 2'b11);

  // A 32-bit instruction waits until both of its halves are queued, which is
  // what makes straddling instructions come out whole.
  assign out_valid = is_32 ? (count >= CW'(2)) : (count != '0);

  assign fetch_ready = rst_n && (count <= MAX_FILL) && !flush;
  assign in_fire     = fetch_valid && fetch_ready;
  assign out_fire    = out_valid && instr_ready && !flush;

  assign n_in  = !in_fire  ? 2'd0 : (drop_hw ? 2'd1 : 2'd2);
  assign n_out = !out_fire ? 2'd0 : (is_32   ? 2'd2 : 2'd1);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sel_data    = '0;
    sel_illegal = 1'b0;
    if (is_32) begin
      sel_data = {hw1, hw0};
    end else if (hw0 == 16'h0001) begin
      sel_data = 32'h0000_0013;  // c.nop -> addi x0,x0,0
    end else if (hw0[15:13] == 3'b000 && hw0[1:0] == 2'b01 &&
                 hw0[11:7] != 5'd0) begin
      // c.addi rd,imm -> addi rd,rd,sext(imm6)
      sel_data = {{6{hw0[12]}}, hw0[12], hw0[6:2], hw0[11:7], 3'b000,
                  hw0[11:7], 7'b0010011};
    end else begin
      sel_data    = {16'h0000, hw0};
      sel_illegal = 1'b1;
    end
  end

  // Outputs depend only on registered queue state, so they hold while
  // decode stalls.
  assign instr_valid         = out_valid;
  assign instr_data          = out_valid ? sel_data : '0;
  assign instr_pc            = pc;
  assign instr_is_compressed = out_valid && !is_32;
  assign instr_illegal       = out_valid && sel_illegal;

  // NOTE: the queue storage has no reset; head/tail/count decide which
  // entries are meaningful, and stale slots never reach the outputs.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (drop_hw) begin
        mem[tail] <= fetch_data[31:16];
      end else begin
        mem[tail]                <= fetch_data[15:0];
        mem[idx_add(tail, 2'd1)] <= fetch_data[31:16];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pc      <= RESET_PC;
      drop_hw <= 1'b0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pc      <= flush_pc & ~32'h1;
      // A redirect to the upper halfword discards the lower half of the
      // next fetched word.
      drop_hw <= flush_pc[1];
    end else begin
      head  <= idx_add(head, n_out);
      tail  <= idx_add(tail, n_in);
      count <= count + CW'(n_in) - CW'(n_out);
      if (out_fire) pc <= pc + (is_32 ? 32'd4 : 32'd2);
      if (in_fire)  drop_hw <= 1'b0;
    end
  end

`else

  logic [31:0] word;
  logic        full;
  logic [31:0] pc;
  logic        in_fire;
  logic        out_fire;

  assign fetch_ready = rst_n && !full && !flush;
  assign in_fire     = fetch_valid && fetch_ready;
  assign out_fire    = full && instr_ready && !flush;

  assign instr_valid         = full;
  assign instr_data          = full ? word : '0;
  assign instr_pc            = pc;
  assign instr_is_compressed = 1'b0;
  assign instr_illegal       = full && (word[1:0] != 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      full <= 1'b0;
      pc   <= RESET_PC;
    end else if (flush) begin
      full <= 1'b0;
      // Only word-aligned targets exist without halfword alignment.
      pc   <= flush_pc & ~32'h3;
    end else begin
      if (in_fire) begin
        word <= fetch_data;
        full <= 1'b1;
      end else if (out_fire) begin
        full <= 1'b0;
      end
      if (out_fire) pc <= pc + 32'd4;
    end
  end

`endif

endmodule

// File: tb/tb_instr_align_expand.sv
// ---------------------------------------------------------------------------
// Self-checking bench for instr_align_expand. A queue-based reference model
// tracks buffered halfwords (or words without QUINTA_RVC_EN) and the PC and
// predicts every output each cycle. Directed sequences cover the known
// answers; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_instr_align_expand;

  localparam int          BUF_HW   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;
  logic        instr_illegal;

  instr_align_expand #(.BUF_HW(BUF_HW), .RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_valid         (fetch_valid),
    .fetch_ready         (fetch_ready),
    .fetch_data          (fetch_data),
    .flush               (flush),
    .flush_pc            (flush_pc),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_data          (instr_data),
    .instr_pc            (instr_pc),
    .instr_is_compressed (instr_is_compressed),
    .instr_illegal       (instr_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
`ifdef QUINTA_RVC_EN
  logic [15:0] mq[$];
  bit          mdrop = 0;
`else
  logic [31:0] mq[$];
`endif
  logic [31:0] mpc = RESET_PC;

  function automatic logic [31:0] rvc_expand(input logic [15:0] h,
                                             output bit il);
    int rd;
    int imm;
    il  = 0;
    rd  = int'((h >> 7) & 16'h1F);
    imm = int'((h >> 2) & 16'h1F);
    if (h[12]) imm = imm - 32;
    if (h == 16'h0001) return 32'h0000_0013;
    if ((h >> 13) == 16'd0 && (h & 16'h3) == 16'd1 && rd != 0)
      return ((32'(imm) & 32'hFFF) << 20) | (32'(rd) << 15) |
             (32'(rd) << 7) | 32'h13;
    il = 1;
    return {16'h0000, h};
  endfunction

  task automatic model_out(output bit v, output logic [31:0] d, output bit c,
                           output bit il, output int len);
    v = 0; d = '0; c = 0; il = 0; len = 0;
    if (mq.size() == 0) return;
`ifdef QUINTA_RVC_EN
    if (mq[0][1:0] == 2'b11) begin
      if (mq.size() < 2) return;
      v = 1; d = {mq[1], mq[0]}; len = 2;
    end else begin
      v = 1; c = 1; len = 1;
      d = rvc_expand(mq[0], il);
    end
`else
    v = 1; d = mq[0]; len = 1; il = (mq[0][1:0] != 2'b11);
`endif
  endtask

  function automatic bit model_ready(input bit fl);
`ifdef QUINTA_RVC_EN
    return (BUF_HW - mq.size() >= 2) && !fl;
`else
    return (mq.size() == 0) && !fl;
`endif
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  // Entered and left at a falling edge.
  task automatic step(input bit fv, input logic [31:0] fd, input bit ir,
                      input bit fl, input logic [31:0] fpc);
    bit v, c, il, rdy;
    logic [31:0] d;
    int len;
    fetch_valid = fv; fetch_data = fd; instr_ready = ir;
    flush = fl; flush_pc = fpc;
    #1;
    model_out(v, d, c, il, len);
    rdy = model_ready(fl);
    check("fetch_ready", 32'(fetch_ready), 32'(rdy));
    check("instr_valid", 32'(instr_valid), 32'(v));
    check("instr_pc", instr_pc, mpc);
    if (v) begin
      check("instr_data", instr_data, d);
      check("instr_is_compressed", 32'(instr_is_compressed), 32'(c));
      check("instr_illegal", 32'(instr_illegal), 32'(il));
    end
    @(posedge clk);
    if (fl) begin
      mq.delete();
`ifdef QUINTA_RVC_EN
      mpc   = fpc & ~32'h1;
      mdrop = fpc[1];
`else
      mpc = fpc & ~32'h3;
`endif
    end else begin
      if (v && ir) begin
        for (int k = 0; k < len; k++) void'(mq.pop_front());
`ifdef QUINTA_RVC_EN
        mpc = mpc + 32'(2 * len);
`else
        mpc = mpc + 32'd4;
`endif
      end
      if (fv && rdy) begin
`ifdef QUINTA_RVC_EN
        if (!mdrop) mq.push_back(fd[15:0]);
        mq.push_back(fd[31:16]);
        mdrop = 0;
`else
        mq.push_back(fd);
`endif
      end
    end
    @(negedge clk);
  endtask

  // Known-answer check of the instruction currently presented.
  task automatic expect_out(input string tag, input logic [31:0] d,
                            input logic [31:0] pc, input bit c, input bit il);
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".data"}, instr_data, d);
    check({tag, ".pc"}, instr_pc, pc);
    check({tag, ".compressed"}, 32'(instr_is_compressed), 32'(c));
    check({tag, ".illegal"}, 32'(instr_illegal), 32'(il));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 3))
      0: h = 16'h0001;
      1: begin h[15:13] = 3'b000; h[1:0] = 2'b01; end
      2: h[1:0] = 2'b11;
      default: ;
    endcase
    return h;
  endfunction

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = '0; instr_ready = 1'b0;
    flush = 1'b0; flush_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst.instr_valid", 32'(instr_valid), 32'd0);
    check("rst.instr_data", instr_data, 32'd0);
    check("rst.instr_pc", instr_pc, RESET_PC);
    check("rst.compressed", 32'(instr_is_compressed), 32'd0);
    check("rst.illegal", 32'(instr_illegal), 32'd0);
    rst_n = 1'b1;

    // First instruction straight after reset, one-cycle latency.
    step(1, 32'h00A0_0093, 1, 0, 0);
    expect_out("t1", 32'h00A0_0093, 32'h0, 0, 0);
    step(0, 0, 1, 0, 0);

`ifdef QUINTA_RVC_EN
    // Two compressed instructions in one word.
    step(0, 0, 0, 1, 32'h0);
    expect_idle("t2.flush");
    step(1, 32'h0505_0001, 0, 0, 0);
    expect_out("t2a", 32'h0000_0013, 32'h0, 1, 0);
    step(0, 0, 1, 0, 0);
    expect_out("t2b", 32'h0015_0513, 32'h2, 1, 0);
    step(0, 0, 1, 0, 0);

    // Negative immediate, then an unsupported encoding.
    step(0, 0, 0, 1, 32'h0);
    step(1, 32'h0000_157D, 0, 0, 0);
    expect_out("t3a", 32'hFFF5_0513, 32'h0, 1, 0);
    step(0, 0, 1, 0, 0);
    expect_out("t3b", 32'h0000_0000, 32'h2, 1, 1);
    step(0, 0, 1, 0, 0);

    // Straddling 32-bit instruction waits for its upper half.
    step(0, 0, 0, 1, 32'h0);
    step(1, 32'h0093_0001, 0, 0, 0);
    expect_out("t4a", 32'h0000_0013, 32'h0, 1, 0);
    step(0, 0, 1, 0, 0);
    expect_idle("t4.half");
    step(1, 32'h0001_00A0, 0, 0, 0);
    expect_out("t4b", 32'h00A0_0093, 32'h2, 0, 0);
    step(0, 0, 1, 0, 0);
    expect_out("t4c", 32'h0000_0013, 32'h6, 1, 0);
    step(0, 0, 1, 0, 0);

    // Redirect into the upper halfword drops the lower half.
    step(0, 0, 0, 1, 32'h0000_0102);
    expect_idle("t5.flush");
    step(1, 32'h0505_FFFF, 0, 0, 0);
    expect_out("t5", 32'h0015_0513, 32'h102, 1, 0);
    step(0, 0, 1, 0, 0);
`else
    // Non-32-bit encodings pass through flagged illegal.
    step(0, 0, 0, 1, 32'h0);
    expect_idle("n2.flush");
    step(1, 32'h0505_0001, 0, 0, 0);
    expect_out("n2", 32'h0505_0001, 32'h0, 0, 1);
    step(0, 0, 1, 0, 0);

    // Redirect target.
    step(0, 0, 0, 1, 32'h0000_0101);
    step(1, 32'h00A0_0093, 0, 0, 0);
    expect_out("n3", 32'h00A0_0093, 32'h100, 0, 0);
    step(0, 0, 1, 0, 0);
`endif

    // Back-pressure with 32-bit words, then drain with overlapping handshakes.
    step(0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 32'h0000_0093 | (32'(i) << 20), 0, 0, 0);
    for (int i = 5; i < 12; i++) step(1, 32'h0000_0093 | (32'(i) << 20), 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] fpc;
      fpc = $urandom;
`ifndef QUINTA_RVC_EN
      fpc[1] = 1'b0;
`endif
      step($urandom_range(0, 9) < 7, {rand_hw(), rand_hw()},
           $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, fpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
